// File: rtl/alu_seq_ctrl_if.sv
// Bundle of command, load, ALU-side and result signals for alu_seq_ctrl.
// The slave modport is the controller's view; master is the view of whoever
// issues commands and consumes results (and also models the ALU).
interface alu_seq_ctrl_if #(
  parameter int NREG = 8,
  parameter int ERRW = 8
);
  localparam int AW = $clog2(NREG);

  // register-file load port
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;

  // command handshake
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_mode;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rd;
  logic          cmd_wb;

  // ALU side
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic          alu_mode;
  logic [1:0]    alu_op;
  logic [31:0]   alu_res;
  logic          alu_err;

  // result handshake and status
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          res_err;
  logic [AW-1:0] res_rd;
  logic [ERRW-1:0] err_cnt;

  modport slave (
    input  ld_en, ld_addr, ld_data,
    input  cmd_valid, cmd_mode, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
    output cmd_ready,
    output alu_a, alu_b, alu_mode, alu_op,
    input  alu_res, alu_err,
    output res_valid, res_data, res_err, res_rd, err_cnt,
    input  res_ready
  );

  modport master (
    output ld_en, ld_addr, ld_data,
    output cmd_valid, cmd_mode, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
    input  cmd_ready,
    input  alu_a, alu_b, alu_mode, alu_op,
    output alu_res, alu_err,
    input  res_valid, res_data, res_err, res_rd, err_cnt,
    output res_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequential front end for the combinational 16-bit two-mode ALU.
// Accepts a command, drives operands from an internal register file for one
// ISSUE cycle, captures the ALU result, optionally writes the low half back,
// and holds the result until the consumer takes it.
module alu_seq_ctrl #(
  parameter int NREG = 8,
  parameter int ERRW = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(NREG);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [15:0]     rf_q [NREG];
  logic [15:0]     rf_d [NREG];

  logic [AW-1:0]   rd_q;
  logic            wb_q;

  logic [15:0]     alu_a_q, alu_b_q;
  logic            alu_mode_q;
  logic [1:0]      alu_op_q;

  logic            cmd_ready_q;
  logic            res_valid_q;
  logic [31:0]     res_data_q;
  logic            res_err_q;
  logic [AW-1:0]   res_rd_q;
  logic [ERRW-1:0] err_cnt_q;

  logic            accept_s;
  logic            issue_s;
  logic            wb_fire_s;
  logic            err_sat_s;

  assign accept_s  = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign issue_s   = (state_q == ST_ISSUE);
  assign wb_fire_s = issue_s && wb_q && !bus.alu_err;
  assign err_sat_s = (err_cnt_q == {ERRW{1'b1}});

  // Next-state logic for the IDLE -> ISSUE -> RESP sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next register-file contents: load first, writeback applied last so it wins a collision.
  always_comb begin
    rf_d = rf_q;
    if (bus.ld_en) begin
      rf_d[bus.ld_addr] = bus.ld_data;
    end else begin
      rf_d[bus.ld_addr] = rf_q[bus.ld_addr];
    end
    if (wb_fire_s) begin
      rf_d[rd_q] = bus.alu_res[15:0];
    end else begin
      rf_d[rd_q] = rf_d[rd_q];
    end
  end

  // FSM state and the handshake flags, which are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      res_valid_q <= (state_d == ST_RESP);
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Command capture. Operands are read through rf_d so that a load landing on
  // the accept edge is what the ALU sees; rf cannot change again until ISSUE ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q       <= {AW{1'b0}};
      wb_q       <= 1'b0;
      alu_a_q    <= 16'h0000;
      alu_b_q    <= 16'h0000;
      alu_mode_q <= 1'b0;
      alu_op_q   <= 2'b00;
    end else if (accept_s) begin
      rd_q       <= bus.cmd_rd;
      wb_q       <= bus.cmd_wb;
      alu_a_q    <= rf_d[bus.cmd_ra];
      alu_b_q    <= rf_d[bus.cmd_rb];
      alu_mode_q <= bus.cmd_mode;
      alu_op_q   <= bus.cmd_op;
    end else begin
      rd_q       <= rd_q;
      wb_q       <= wb_q;
      alu_a_q    <= alu_a_q;
      alu_b_q    <= alu_b_q;
      alu_mode_q <= alu_mode_q;
      alu_op_q   <= alu_op_q;
    end
  end

  // Result capture at the end of ISSUE; held stable through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data_q <= 32'h0000_0000;
      res_err_q  <= 1'b0;
      res_rd_q   <= {AW{1'b0}};
    end else if (issue_s) begin
      res_data_q <= bus.alu_res;
      res_err_q  <= bus.alu_err;
      res_rd_q   <= rd_q;
    end else begin
      res_data_q <= res_data_q;
      res_err_q  <= res_err_q;
      res_rd_q   <= res_rd_q;
    end
  end

  // Saturating count of commands whose ALU result carried an error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= {ERRW{1'b0}};
    end else if (issue_s && bus.alu_err && !err_sat_s) begin
      err_cnt_q <= err_cnt_q + {{(ERRW-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_mode  = alu_mode_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a behavioural ALU model sits on the
// ALU side, a table of commands with hand-computed results is run in a loop,
// and hand-written sequences cover backpressure, load/writeback collision and
// reset during RESP.
module tb_alu_seq_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_ctrl_if #(.NREG(8), .ERRW(8)) bus ();

  alu_seq_ctrl #(.NREG(8), .ERRW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: logic ops zero-extended, math ops on sign-extended operands.
  logic signed [31:0] ea_s, eb_s;
  always_comb begin
    ea_s = {{16{bus.alu_a[15]}}, bus.alu_a};
    eb_s = {{16{bus.alu_b[15]}}, bus.alu_b};
    bus.alu_res = 32'h0000_0000;
    bus.alu_err = 1'b0;
    case ({bus.alu_mode, bus.alu_op})
      3'b000: bus.alu_res = {16'h0000, bus.alu_a & bus.alu_b};
      3'b001: bus.alu_res = {16'h0000, bus.alu_a | bus.alu_b};
      3'b010: bus.alu_res = {16'h0000, bus.alu_a ^ bus.alu_b};
      3'b011: bus.alu_res = {16'h0000, ~bus.alu_a};
      3'b100: bus.alu_res = ea_s + eb_s;
      3'b101: bus.alu_res = ea_s - eb_s;
      3'b110: bus.alu_res = ea_s * eb_s;
      3'b111: begin
        if (bus.alu_b == 16'h0000) begin
          bus.alu_err = 1'b1;
          bus.alu_res = 32'h0000_0000;
        end else begin
          bus.alu_res = ea_s / eb_s;
        end
      end
      default: bus.alu_res = 32'h0000_0000;
    endcase
  end

  typedef struct {
    string       name;
    logic        mode;
    logic [1:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic        wb;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Load one register; called and returns just after a falling edge.
  task automatic ld(input logic [2:0] a, input logic [15:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(negedge clk);
    bus.ld_en   = 1'b0;
  endtask

  task automatic drive_cmd(input logic m, input logic [1:0] o, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [2:0] rd, input logic wb);
    bus.cmd_mode = m;
    bus.cmd_op   = o;
    bus.cmd_ra   = ra;
    bus.cmd_rb   = rb;
    bus.cmd_rd   = rd;
    bus.cmd_wb   = wb;
  endtask

  // Wait (bounded) for res_valid; n returns the number of falling edges waited.
  task automatic wait_res(input string nm, output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) begin
      chk({nm, "_timeout"}, 32'(bus.res_valid), 32'd1);
    end
  endtask

  // Full command transaction with res_ready high; optional load on the accept edge.
  task automatic run_cmd(input string nm, input logic m, input logic [1:0] o,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                         input logic wb, input logic lden, input logic [2:0] la,
                         input logic [15:0] lv, output logic [31:0] res,
                         output logic err, output logic [2:0] rdo);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    drive_cmd(m, o, ra, rb, rd, wb);
    bus.ld_en     = lden;
    bus.ld_addr   = la;
    bus.ld_data   = lv;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.ld_en     = 1'b0;
    chk({nm, "_issue_busy"}, {30'd0, bus.cmd_ready, bus.res_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_latency"}, 32'(bus.res_valid), 32'd1);
    wait_res(nm, n);
    res = bus.res_data;
    err = bus.res_err;
    rdo = bus.res_rd;
    @(negedge clk);
    chk({nm, "_done"}, {30'd0, bus.cmd_ready, bus.res_valid}, 32'd2);
  endtask

  logic [31:0] r;
  logic        e;
  logic [2:0]  rdo;
  int          n;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = 3'd0; bus.ld_data = 16'h0000;
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
    drive_cmd(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);

    vecs.push_back('{name:"add",       mode:1'b1, op:2'b00, ra:3'd0, rb:3'd1, rd:3'd2, wb:1'b1, exp_res:32'h0000_003B, exp_err:1'b0});
    vecs.push_back('{name:"and_wb",    mode:1'b0, op:2'b00, ra:3'd2, rb:3'd2, rd:3'd0, wb:1'b0, exp_res:32'h0000_003B, exp_err:1'b0});
    vecs.push_back('{name:"mult",      mode:1'b1, op:2'b10, ra:3'd3, rb:3'd4, rd:3'd3, wb:1'b0, exp_res:32'h3FFF_0001, exp_err:1'b0});
    vecs.push_back('{name:"mult_nowb", mode:1'b0, op:2'b01, ra:3'd3, rb:3'd3, rd:3'd1, wb:1'b0, exp_res:32'h0000_7FFF, exp_err:1'b0});
    vecs.push_back('{name:"div0",      mode:1'b1, op:2'b11, ra:3'd5, rb:3'd6, rd:3'd5, wb:1'b1, exp_res:32'h0000_0000, exp_err:1'b1});
    vecs.push_back('{name:"div0_rf",   mode:1'b0, op:2'b01, ra:3'd5, rb:3'd5, rd:3'd0, wb:1'b0, exp_res:32'h0000_FFD6, exp_err:1'b0});
    vecs.push_back('{name:"sub",       mode:1'b1, op:2'b01, ra:3'd0, rb:3'd1, rd:3'd3, wb:1'b1, exp_res:32'h0000_0005, exp_err:1'b0});
    vecs.push_back('{name:"xor",       mode:1'b0, op:2'b10, ra:3'd3, rb:3'd1, rd:3'd0, wb:1'b0, exp_res:32'h0000_001E, exp_err:1'b0});
    vecs.push_back('{name:"not",       mode:1'b0, op:2'b11, ra:3'd0, rb:3'd1, rd:3'd7, wb:1'b0, exp_res:32'h0000_FFDF, exp_err:1'b0});
    vecs.push_back('{name:"divneg",    mode:1'b1, op:2'b11, ra:3'd5, rb:3'd1, rd:3'd6, wb:1'b0, exp_res:32'hFFFF_FFFF, exp_err:1'b0});
    vecs.push_back('{name:"subneg",    mode:1'b1, op:2'b01, ra:3'd1, rb:3'd0, rd:3'd4, wb:1'b0, exp_res:32'hFFFF_FFFB, exp_err:1'b0});
    vecs.push_back('{name:"self_add",  mode:1'b1, op:2'b00, ra:3'd3, rb:3'd3, rd:3'd3, wb:1'b1, exp_res:32'h0000_000A, exp_err:1'b0});
    vecs.push_back('{name:"self_chk",  mode:1'b0, op:2'b00, ra:3'd3, rb:3'd3, rd:3'd7, wb:1'b0, exp_res:32'h0000_000A, exp_err:1'b0});

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  bus.res_data, 32'd0);
    chk("rst_err_cnt",   32'(bus.err_cnt), 32'd0);
    chk("rst_alu_ab",    {bus.alu_a, bus.alu_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    ld(3'd0, 16'h0020);
    ld(3'd1, 16'h001B);
    ld(3'd3, 16'h7FFF);
    ld(3'd4, 16'h7FFF);
    ld(3'd5, 16'hFFD6);
    ld(3'd6, 16'h0000);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].name, vecs[i].mode, vecs[i].op, vecs[i].ra, vecs[i].rb,
              vecs[i].rd, vecs[i].wb, 1'b0, 3'd0, 16'h0000, r, e, rdo);
      chk({vecs[i].name, "_res"}, r, vecs[i].exp_res);
      chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_rd"},  32'(rdo), 32'(vecs[i].rd));
    end
    chk("err_cnt_after_table", 32'(bus.err_cnt), 32'd1);

    // Load on the accept edge is seen by the ISSUE read.
    run_cmd("ld_accept", 1'b0, 2'b01, 3'd7, 3'd7, 3'd0, 1'b0, 1'b1, 3'd7, 16'h0011, r, e, rdo);
    chk("ld_accept_res", r, 32'h0000_0011);

    // Backpressure: result held 5+ cycles while a second command waits.
    drive_cmd(1'b1, 2'b00, 3'd0, 3'd1, 3'd4, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    drive_cmd(1'b0, 2'b01, 3'd4, 3'd4, 3'd6, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_data",  bus.res_data, 32'h0000_003B);
      chk("bp_rd",    32'(bus.res_rd), 32'd4);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, bus.cmd_ready, bus.res_valid}, 32'd2);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_second_accepted", 32'(bus.cmd_ready), 32'd0);
    wait_res("bp_second", n);
    chk("bp_second_data", bus.res_data, 32'h0000_003B);
    chk("bp_second_rd",   32'(bus.res_rd), 32'd6);
    @(negedge clk);

    // Load and writeback to the same register on the ISSUE edge: writeback wins.
    ld(3'd6, 16'h0030);
    drive_cmd(1'b1, 2'b00, 3'd0, 3'd6, 3'd2, 1'b1);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'd2;
    bus.ld_data = 16'h1234;
    @(negedge clk);
    bus.ld_en = 1'b0;
    chk("coll_res", bus.res_data, 32'h0000_0050);
    @(negedge clk);
    run_cmd("coll_rf", 1'b0, 2'b01, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, r, e, rdo);
    chk("coll_rf_res", r, 32'h0000_0050);

    // Reset while an errored result waits in RESP.
    ld(3'd6, 16'h0000);
    drive_cmd(1'b1, 2'b11, 3'd5, 3'd6, 3'd5, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rr_in_resp", {30'd0, bus.res_valid, bus.res_err}, 32'd3);
    chk("rr_err_cnt", 32'(bus.err_cnt), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rr_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rr_err_cnt0",  32'(bus.err_cnt), 32'd0);
    chk("rr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_release", 32'(bus.cmd_ready), 32'd1);
    run_cmd("rr_rf5", 1'b0, 2'b01, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, r, e, rdo);
    chk("rr_rf5_res", r, 32'h0000_0000);
    run_cmd("rr_rf01", 1'b0, 2'b01, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, r, e, rdo);
    chk("rr_rf01_res", r, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
